link_register_unit: RTL and testbench

LINK_REGISTER_UNIT -- requirements
Module: link_register_unit

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/link_register_if.sv | 26 ++
 rtl/link_register_unit.sv | 108 ++++++++++
 tb/tb_link_register_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word type and link register FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINKED = 2'd1,
        COMMIT = 2'd2
    } linkstate_t;

    localparam logic [15:0] FAIL_CNT_MAX = 16'hFFFF;

    // Saturating increment for the failed-SC counter
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == FAIL_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/link_register_if.sv
// rtl/link_register_if.sv - LL/SC link register port bundle
interface link_register_if;
    import cpu_types_pkg::*;

    logic        LinkedLoad;
    logic        StoreConditional;
    logic        dmemREN;
    logic        dmemWEN;
    word_t       dmemaddr;
    logic        dhit;
    logic        snoopvalid;
    word_t       snoopaddr;
    logic        scAllow;
    logic        scDone;
    word_t       scResult;
    logic        linkValid;
    logic [29:0] linkAddr;
    logic [15:0] scFailCount;

    modport lr (
        input  LinkedLoad, StoreConditional, dmemREN, dmemWEN, dmemaddr,
        input  dhit, snoopvalid, snoopaddr,
        output scAllow, scDone, scResult, linkValid, linkAddr, scFailCount
    );

endinterface

// File: rtl/link_register_unit.sv
// rtl/link_register_unit.sv - LL/SC reservation tracker with snoop invalidation
module link_register_unit
    import cpu_types_pkg::*;
(
    input logic        CLK,
    input logic        nRST,
    link_register_if.lr lrif
);

    linkstate_t  state_q, state_d;
    logic [29:0] link_addr_q, link_addr_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    logic sc_allow, sc_done, sc_success, sc_fail;
    logic ll_done, sc_req, word_match, snoop_match, plain_store;

    assign ll_done     = lrif.LinkedLoad & lrif.dmemREN & lrif.dhit;
    assign sc_req      = lrif.StoreConditional & lrif.dmemWEN;
    assign word_match  = (lrif.dmemaddr[31:2] == link_addr_q);
    assign snoop_match = lrif.snoopvalid & (lrif.snoopaddr[31:2] == link_addr_q);
    assign plain_store = lrif.dmemWEN & ~lrif.StoreConditional & lrif.dhit;

    // State, reservation address and failure counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            link_addr_q <= 30'd0;
            fail_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Next-state logic and SC resolution; an LL completion takes priority over a snoop
    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        sc_allow    = 1'b0;
        sc_done     = 1'b0;
        sc_success  = 1'b0;
        sc_fail     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ll_done) begin
                    state_d     = LINKED;
                    link_addr_d = lrif.dmemaddr[31:2];
                end else if (sc_req) begin
                    sc_done = 1'b1;
                    sc_fail = 1'b1;
                end
            end
            LINKED: begin
                if (ll_done) begin
                    link_addr_d = lrif.dmemaddr[31:2];
                end else if (sc_req) begin
                    if (word_match && !snoop_match) begin
                        sc_allow = 1'b1;
                        if (lrif.dhit) begin
                            sc_done    = 1'b1;
                            sc_success = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = COMMIT;
                        end
                    end else begin
                        sc_done = 1'b1;
                        sc_fail = 1'b1;
                        state_d = IDLE;
                    end
                end else if (plain_store && word_match) begin
                    state_d = IDLE;
                end else if (snoop_match) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // The write has already been issued; a dhit means it landed even if a snoop arrives alongside
                if (lrif.StoreConditional) begin
                    if (lrif.dhit) begin
                        sc_allow   = 1'b1;
                        sc_done    = 1'b1;
                        sc_success = 1'b1;
                        state_d    = IDLE;
                    end else if (snoop_match) begin
                        sc_done = 1'b1;
                        sc_fail = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sc_allow = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        fail_cnt_d = sc_fail ? sat_inc(fail_cnt_q) : fail_cnt_q;
    end

    // Outputs are forced low while reset is held, even if the pipeline still presents an SC
    assign lrif.scAllow     = sc_allow & nRST;
    assign lrif.scDone      = sc_done & nRST;
    assign lrif.scResult    = {31'd0, sc_success & nRST};
    assign lrif.linkValid   = (state_q != IDLE);
    assign lrif.linkAddr    = link_addr_q;
    assign lrif.scFailCount = fail_cnt_q;

endmodule

// File: tb/tb_link_register_unit.sv
// tb/tb_link_register_unit.sv - directed self-checking bench for link_register_unit
module tb_link_register_unit;

    logic clk;
    logic nrst;
    int   errors;
    int   checks;

    link_register_if lrif();

    link_register_unit dut (
        .CLK  (clk),
        .nRST (nrst),
        .lrif (lrif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        lrif.LinkedLoad       = 1'b0;
        lrif.StoreConditional = 1'b0;
        lrif.dmemREN          = 1'b0;
        lrif.dmemWEN          = 1'b0;
        lrif.dmemaddr         = 32'd0;
        lrif.dhit             = 1'b0;
        lrif.snoopvalid       = 1'b0;
        lrif.snoopaddr        = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ll(input logic [31:0] addr);
        clear_inputs();
        lrif.LinkedLoad = 1'b1;
        lrif.dmemREN    = 1'b1;
        lrif.dhit       = 1'b1;
        lrif.dmemaddr   = addr;
        step();
        clear_inputs();
    endtask

    task automatic drive_sc(input logic [31:0] addr, input logic hit);
        clear_inputs();
        lrif.StoreConditional = 1'b1;
        lrif.dmemWEN          = 1'b1;
        lrif.dmemaddr         = addr;
        lrif.dhit             = hit;
    endtask

    task automatic test_reset();
        clear_inputs();
        nrst = 1'b0;
        #12;
        checks++; if (lrif.linkValid !== 1'b0) begin errors++; $display("FAIL reset_linkValid: got %0b expected 0", lrif.linkValid); end
        checks++; if (lrif.linkAddr !== 30'd0) begin errors++; $display("FAIL reset_linkAddr: got %0h expected 0", lrif.linkAddr); end
        checks++; if (lrif.scFailCount !== 16'd0) begin errors++; $display("FAIL reset_scFailCount: got %0h expected 0", lrif.scFailCount); end
        checks++; if (lrif.scDone !== 1'b0 || lrif.scAllow !== 1'b0) begin errors++; $display("FAIL reset_sc_outputs: got done=%0b allow=%0b expected 0 0", lrif.scDone, lrif.scAllow); end
        @(negedge clk);
        nrst = 1'b1;
        step();
    endtask

    task automatic test_sc_success();
        do_ll(32'h0000_0104);
        checks++; if (lrif.linkValid !== 1'b1 || lrif.linkAddr !== 30'h41) begin errors++; $display("FAIL ll_set: got valid=%0b addr=%0h expected 1 41", lrif.linkValid, lrif.linkAddr); end
        drive_sc(32'h0000_0106, 1'b0);
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b1 || lrif.scDone !== 1'b0) begin errors++; $display("FAIL sc_issue: got allow=%0b done=%0b expected 1 0", lrif.scAllow, lrif.scDone); end
        step();
        lrif.dhit = 1'b1;
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b1 || lrif.scDone !== 1'b1 || lrif.scResult !== 32'd1) begin errors++; $display("FAIL sc_success: got allow=%0b done=%0b result=%0h expected 1 1 1", lrif.scAllow, lrif.scDone, lrif.scResult); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.linkValid !== 1'b0 || lrif.scDone !== 1'b0) begin errors++; $display("FAIL sc_success_after: got valid=%0b done=%0b expected 0 0", lrif.linkValid, lrif.scDone); end
        checks++; if (lrif.scFailCount !== 16'd0) begin errors++; $display("FAIL sc_success_count: got %0h expected 0", lrif.scFailCount); end
    endtask

    task automatic test_sc_mismatch();
        do_ll(32'h0000_0100);
        drive_sc(32'h0000_0200, 1'b0);
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b0 || lrif.scDone !== 1'b1 || lrif.scResult !== 32'd0) begin errors++; $display("FAIL sc_mismatch: got allow=%0b done=%0b result=%0h expected 0 1 0", lrif.scAllow, lrif.scDone, lrif.scResult); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.scFailCount !== 16'd1 || lrif.linkValid !== 1'b0) begin errors++; $display("FAIL sc_mismatch_after: got count=%0h valid=%0b expected 1 0", lrif.scFailCount, lrif.linkValid); end
    endtask

    task automatic test_commit_snoop();
        do_ll(32'h0000_0100);
        drive_sc(32'h0000_0100, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (lrif.scAllow !== 1'b1 || lrif.scDone !== 1'b0) begin errors++; $display("FAIL commit_wait%0d: got allow=%0b done=%0b expected 1 0", i, lrif.scAllow, lrif.scDone); end
            step();
        end
        lrif.snoopvalid = 1'b1;
        lrif.snoopaddr  = 32'h0000_0103;
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b0 || lrif.scDone !== 1'b1 || lrif.scResult !== 32'd0) begin errors++; $display("FAIL commit_abort: got allow=%0b done=%0b result=%0h expected 0 1 0", lrif.scAllow, lrif.scDone, lrif.scResult); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.scFailCount !== 16'd2 || lrif.linkValid !== 1'b0) begin errors++; $display("FAIL commit_abort_after: got count=%0h valid=%0b expected 2 0", lrif.scFailCount, lrif.linkValid); end
        do_ll(32'h0000_0100);
        drive_sc(32'h0000_0100, 1'b0);
        step();
        lrif.dhit       = 1'b1;
        lrif.snoopvalid = 1'b1;
        lrif.snoopaddr  = 32'h0000_0100;
        @(negedge clk);
        checks++; if (lrif.scDone !== 1'b1 || lrif.scResult !== 32'd1) begin errors++; $display("FAIL commit_snoop_dhit: got done=%0b result=%0h expected 1 1", lrif.scDone, lrif.scResult); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.scFailCount !== 16'd2 || lrif.scDone !== 1'b0) begin errors++; $display("FAIL commit_snoop_dhit_after: got count=%0h done=%0b expected 2 0", lrif.scFailCount, lrif.scDone); end
    endtask

    task automatic test_store_kill();
        do_ll(32'h0000_0100);
        lrif.dmemWEN  = 1'b1;
        lrif.dhit     = 1'b1;
        lrif.dmemaddr = 32'h0000_0104;
        @(negedge clk);
        checks++; if (lrif.scDone !== 1'b0 || lrif.scAllow !== 1'b0 || lrif.scResult !== 32'd0) begin errors++; $display("FAIL store_no_sc_out: got done=%0b allow=%0b result=%0h expected 0 0 0", lrif.scDone, lrif.scAllow, lrif.scResult); end
        step();
        checks++; if (lrif.linkValid !== 1'b1) begin errors++; $display("FAIL store_other_word: got valid=%0b expected 1", lrif.linkValid); end
        lrif.dmemaddr = 32'h0000_0102;
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.linkValid !== 1'b0 || lrif.linkAddr !== 30'h40) begin errors++; $display("FAIL store_same_word: got valid=%0b addr=%0h expected 0 40", lrif.linkValid, lrif.linkAddr); end
        drive_sc(32'h0000_0100, 1'b1);
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b0 || lrif.scDone !== 1'b1 || lrif.scResult !== 32'd0) begin errors++; $display("FAIL sc_after_store: got allow=%0b done=%0b result=%0h expected 0 1 0", lrif.scAllow, lrif.scDone, lrif.scResult); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.scFailCount !== 16'd3) begin errors++; $display("FAIL sc_after_store_count: got %0h expected 3", lrif.scFailCount); end
    endtask

    task automatic test_snoop_ll();
        do_ll(32'h0000_0100);
        lrif.snoopvalid = 1'b1;
        lrif.snoopaddr  = 32'h0000_0200;
        step();
        checks++; if (lrif.linkValid !== 1'b1) begin errors++; $display("FAIL snoop_other: got valid=%0b expected 1", lrif.linkValid); end
        clear_inputs();
        lrif.LinkedLoad = 1'b1;
        lrif.dmemREN    = 1'b1;
        lrif.dhit       = 1'b1;
        lrif.dmemaddr   = 32'h0000_0108;
        lrif.snoopvalid = 1'b1;
        lrif.snoopaddr  = 32'h0000_0100;
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.linkValid !== 1'b1 || lrif.linkAddr !== 30'h42) begin errors++; $display("FAIL ll_wins_snoop: got valid=%0b addr=%0h expected 1 42", lrif.linkValid, lrif.linkAddr); end
        lrif.snoopvalid = 1'b1;
        lrif.snoopaddr  = 32'h0000_010B;
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.linkValid !== 1'b0 || lrif.linkAddr !== 30'h42) begin errors++; $display("FAIL snoop_match: got valid=%0b addr=%0h expected 0 42", lrif.linkValid, lrif.linkAddr); end
    endtask

    task automatic test_reset_commit();
        do_ll(32'h0000_0100);
        drive_sc(32'h0000_0100, 1'b0);
        step();
        @(negedge clk);
        checks++; if (lrif.scAllow !== 1'b1 || lrif.linkValid !== 1'b1) begin errors++; $display("FAIL pre_reset_commit: got allow=%0b valid=%0b expected 1 1", lrif.scAllow, lrif.linkValid); end
        nrst = 1'b0;
        #1;
        checks++; if (lrif.scAllow !== 1'b0 || lrif.scDone !== 1'b0 || lrif.scResult !== 32'd0 || lrif.linkValid !== 1'b0) begin errors++; $display("FAIL reset_in_commit: got allow=%0b done=%0b result=%0h valid=%0b expected 0 0 0 0", lrif.scAllow, lrif.scDone, lrif.scResult, lrif.linkValid); end
        checks++; if (lrif.linkAddr !== 30'd0 || lrif.scFailCount !== 16'd0) begin errors++; $display("FAIL reset_in_commit_regs: got addr=%0h count=%0h expected 0 0", lrif.linkAddr, lrif.scFailCount); end
        step();
        clear_inputs();
        @(negedge clk);
        nrst = 1'b1;
        step();
        checks++; if (lrif.scDone !== 1'b0 || lrif.scFailCount !== 16'd0 || lrif.linkValid !== 1'b0) begin errors++; $display("FAIL after_reset_commit: got done=%0b count=%0h valid=%0b expected 0 0 0", lrif.scDone, lrif.scFailCount, lrif.linkValid); end
    endtask

    task automatic test_saturation();
        drive_sc(32'h0000_0300, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        checks++; if (lrif.scFailCount !== 16'hFFFF) begin errors++; $display("FAIL sat_65536: got %0h expected ffff", lrif.scFailCount); end
        step();
        clear_inputs();
        #1;
        checks++; if (lrif.scFailCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", lrif.scFailCount); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nrst   = 1'b1;
        clear_inputs();
        test_reset();
        test_sc_success();
        test_sc_mismatch();
        test_commit_snoop();
        test_store_kill();
        test_snoop_ll();
        test_reset_commit();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
